// File: rtl/i2c_tx_fifo_if.sv
// i2c_tx_fifo_if: MCU-write / master-FSM-read bus of the I2C transmit FIFO.
//   master modport: request side (write enable/data, read enable, flag clear),
//                   observes data, flags, count and status.
//   slave modport : the FIFO itself.
interface i2c_tx_fifo_if #(
  parameter int unsigned DATA_SIZE  = 8,
  parameter int unsigned DEPTH_LOG2 = 4
);
  logic                  w_fifo_en_i;
  logic [DATA_SIZE-1:0]  data_i;
  logic                  r_fifo_en_i;
  logic                  clear_flags_i;
  logic [DATA_SIZE-1:0]  data_o;
  logic                  full_o;
  logic                  empty_o;
  logic                  almost_full_o;
  logic                  overflow_o;
  logic                  underflow_o;
  logic [DEPTH_LOG2:0]   count_o;
  logic [7:0]            status_o;

  modport master (
    output w_fifo_en_i, data_i, r_fifo_en_i, clear_flags_i,
    input  data_o, full_o, empty_o, almost_full_o, overflow_o, underflow_o,
           count_o, status_o
  );

  modport slave (
    input  w_fifo_en_i, data_i, r_fifo_en_i, clear_flags_i,
    output data_o, full_o, empty_o, almost_full_o, overflow_o, underflow_o,
           count_o, status_o
  );
endinterface

// File: rtl/i2c_tx_fifo.sv
// i2c_tx_fifo: synchronous transmit FIFO between the MCU write path and the
// I2C master core. data_o feeds data_transmit_i of the I2C top.
// Ports:
//   i2c_core_clk_i : clock, all state on rising edge
//   reset_i        : synchronous active-high reset
//   bus            : i2c_tx_fifo_if.slave (requests in; data, flags, count,
//                    status {2'b00, data_valid, underflow, overflow,
//                    almost_full, full, empty} out)
// Build option: define I2C_TX_FIFO_FWFT_EN for first-word-fall-through reads
// (0 latency); default is a registered 1-cycle read.
module i2c_tx_fifo #(
  parameter int unsigned DATA_SIZE    = 8,
  parameter int unsigned DEPTH_LOG2   = 4,
  parameter int unsigned AF_THRESHOLD = 12
) (
  input logic           i2c_core_clk_i,
  input logic           reset_i,
  i2c_tx_fifo_if.slave  bus
);

  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] AF_CNT    = AF_THRESHOLD[DEPTH_LOG2:0];

  logic [DATA_SIZE-1:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2:0]  wptr;
  logic [DEPTH_LOG2:0]  rptr;
  logic [DEPTH_LOG2:0]  count;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic                 overflow;
  logic                 underflow;
  logic                 data_valid;
  logic                 rd_ok;
  logic                 wr_ok;

  always_comb begin
    count       = wptr - rptr;
    empty       = (count == '0);
    full        = (count == DEPTH_CNT);
    almost_full = (count >= AF_CNT);
    rd_ok       = bus.r_fifo_en_i & ~empty;
    // A write while full still lands when a read frees the head slot
    // in the same cycle.
    wr_ok       = bus.w_fifo_en_i & (~full | bus.r_fifo_en_i);
  end

  always_ff @(posedge i2c_core_clk_i) begin
    if (reset_i) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      // New violations win over a simultaneous clear.
      overflow  <= (overflow & ~bus.clear_flags_i)
                 | (bus.w_fifo_en_i & full & ~bus.r_fifo_en_i);
      underflow <= (underflow & ~bus.clear_flags_i)
                 | (bus.r_fifo_en_i & empty);
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge i2c_core_clk_i) begin
    if (!reset_i && wr_ok) mem[wptr[DEPTH_LOG2-1:0]] <= bus.data_i;
  end

`ifdef I2C_TX_FIFO_FWFT_EN
  always_comb begin
    bus.data_o = empty ? '0 : mem[rptr[DEPTH_LOG2-1:0]];
    data_valid = ~empty;
  end
`else
  logic [DATA_SIZE-1:0] rd_data;

  always_ff @(posedge i2c_core_clk_i) begin
    if (reset_i) begin
      rd_data    <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= rd_ok;
      if (rd_ok) rd_data <= mem[rptr[DEPTH_LOG2-1:0]];
    end
  end

  always_comb bus.data_o = rd_data;
`endif

  always_comb begin
    bus.count_o       = count;
    bus.full_o        = full;
    bus.empty_o       = empty;
    bus.almost_full_o = almost_full;
    bus.overflow_o    = overflow;
    bus.underflow_o   = underflow;
    bus.status_o      = {2'b00, data_valid, underflow, overflow,
                         almost_full, full, empty};
  end

endmodule

// File: tb/tb_i2c_tx_fifo.sv
// tb_i2c_tx_fifo: directed plus randomized stimulus for i2c_tx_fifo, checked
// against a queue-based reference model of the FIFO behaviour.
module tb_i2c_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  i2c_tx_fifo_if #(.DATA_SIZE(8), .DEPTH_LOG2(4)) bus ();

  i2c_tx_fifo #(
    .DATA_SIZE   (8),
    .DEPTH_LOG2  (4),
    .AF_THRESHOLD(AF)
  ) dut (
    .i2c_core_clk_i(clk),
    .reset_i       (rst),
    .bus           (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [7:0] q[$];
  logic       m_ovf, m_unf, m_dv;
  logic [7:0] m_dout;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_update(input logic w, input logic [7:0] d,
                              input logic r, input logic clr, input logic rs);
    int n;
    logic was_full, was_empty;
    n = q.size();
    was_full  = (n == DEPTH);
    was_empty = (n == 0);
    if (rs) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_dout = 8'h00; m_dv = 0;
    end else begin
      m_dv = 0;
      if (r && !was_empty) begin
        m_dout = q.pop_front();
        m_dv   = 1;
      end
      if (w && (!was_full || r)) q.push_back(d);
      m_ovf = (m_ovf && !clr) || (w && was_full && !r);
      m_unf = (m_unf && !clr) || (r && was_empty);
    end
`ifdef I2C_TX_FIFO_FWFT_EN
    m_dv   = (q.size() != 0);
    m_dout = m_dv ? q[0] : 8'h00;
`endif
  endtask

  task automatic check_all(input string tag);
    int n;
    logic [7:0] st;
    n  = q.size();
    st = {2'b00, m_dv, m_unf, m_ovf, (n >= AF), (n == DEPTH), (n == 0)};
    check({tag, ".count"}, 32'(bus.count_o), 32'(n));
    check({tag, ".data"},  32'(bus.data_o),  32'(m_dout));
    check({tag, ".status"},32'(bus.status_o),32'(st));
    check({tag, ".flags"},
          {26'd0, bus.empty_o, bus.full_o, bus.almost_full_o,
           bus.overflow_o, bus.underflow_o, 1'b0},
          {26'd0, st[0], st[1], st[2], st[3], st[4], 1'b0});
  endtask

  task automatic step(input string tag, input logic w, input logic [7:0] d,
                      input logic r, input logic clr, input logic rs);
    @(negedge clk);
    bus.w_fifo_en_i   = w;
    bus.data_i        = d;
    bus.r_fifo_en_i   = r;
    bus.clear_flags_i = clr;
    rst               = rs;
    @(posedge clk);
    model_update(w, d, r, clr, rs);
    #1;
    check_all(tag);
    @(negedge clk);
    bus.w_fifo_en_i   = 1'b0;
    bus.r_fifo_en_i   = 1'b0;
    bus.clear_flags_i = 1'b0;
    rst               = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    int wp, rp;
    bus.w_fifo_en_i = 0; bus.data_i = 0; bus.r_fifo_en_i = 0;
    bus.clear_flags_i = 0;
    q.delete(); m_ovf = 0; m_unf = 0; m_dv = 0; m_dout = 0;

    // 1: reset, two writes, one read
    step("rst", 0, 0, 0, 0, 1);
    check("rst.status_const", 32'(bus.status_o), 32'h01);
    step("t1.w0", 1, 8'hA5, 0, 0, 0);
    step("t1.w1", 1, 8'h3C, 0, 0, 0);
    check("t1.count2", 32'(bus.count_o), 32'd2);
    step("t1.rd", 0, 0, 1, 0, 0);
`ifndef I2C_TX_FIFO_FWFT_EN
    check("t1.dataA5", 32'(bus.data_o), 32'hA5);
    check("t1.valid", 32'(bus.status_o[5]), 32'd1);
`endif
    step("t1.idle", 0, 0, 0, 0, 0);
    step("t1.rd2", 0, 0, 1, 0, 0);

    // 2: fill, overflow, drain
    step("t2.rst", 0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) step("t2.fill", 1, 8'(i), 0, 0, 0);
    check("t2.full", 32'(bus.full_o), 32'd1);
    step("t2.ovf", 1, 8'hFF, 0, 0, 0);
    check("t2.ovf_const", 32'(bus.overflow_o), 32'd1);
    for (int i = 0; i < 16; i++) step("t2.drain", 0, 0, 1, 0, 0);
    check("t2.empty", 32'(bus.empty_o), 32'd1);

    // 3: interleaved pairs across pointer wraps
    step("t3.clr", 0, 0, 0, 1, 0);
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      step("t3.w", 1, d, 0, 0, 0);
      check("t3.cnt_le1", 32'(bus.count_o <= 1), 32'd1);
      step("t3.r", 0, 0, 1, 0, 0);
`ifndef I2C_TX_FIFO_FWFT_EN
      check("t3.order", 32'(bus.data_o), 32'(d));
`endif
    end

    // 4: simultaneous r/w while full
    for (int i = 0; i < 16; i++) step("t4.fill", 1, 8'(8'h40 + i), 0, 0, 0);
    step("t4.rw", 1, 8'h77, 1, 0, 0);
    check("t4.cnt16", 32'(bus.count_o), 32'd16);
    check("t4.noovf", 32'(bus.overflow_o), 32'd0);
    for (int i = 0; i < 16; i++) step("t4.drain", 0, 0, 1, 0, 0);
`ifndef I2C_TX_FIFO_FWFT_EN
    check("t4.last77", 32'(bus.data_o), 32'h77);
`endif

    // 5: underflow and sticky clear
    step("t5.udf", 0, 0, 1, 0, 0);
    check("t5.st11", 32'(bus.status_o), 32'h11);
    step("t5.clr", 0, 0, 0, 1, 0);
    check("t5.st01", 32'(bus.status_o), 32'h01);
    step("t5.udf2", 0, 0, 1, 0, 0);
    step("t5.clr_set", 0, 0, 1, 1, 0);
    check("t5.stay", 32'(bus.underflow_o), 32'd1);
    step("t5.empty_rw", 1, 8'h5A, 1, 1, 0);

    // 6: reset mid-operation with a write pending
    for (int i = 0; i < 5; i++) step("t6.fill", 1, 8'(8'h90 + i), 0, 0, 0);
    step("t6.rst", 1, 8'hEE, 0, 0, 1);
    check("t6.st01", 32'(bus.status_o), 32'h01);
    check("t6.data0", 32'(bus.data_o), 32'h00);

    // Randomized phases with varying write/read bias
    for (int ph = 0; ph < 4; ph++) begin
      wp = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
      rp = (ph == 0) ? 25 : (ph == 1) ? 75 : 50;
      for (int i = 0; i < 150; i++) begin
        step("rnd",
             ($urandom_range(99) < wp),
             8'($urandom),
             ($urandom_range(99) < rp),
             ($urandom_range(99) < 5),
             ($urandom_range(199) == 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_tx_fifo.md
Name: i2c_tx_fifo

Overview:
- Synchronous transmit FIFO between the MCU write path and the I2C master core.
- Buffers bytes destined for the SDA line and drives the byte under transmission onto data_transmit_i.
- Driven by the master FSM's read-enable; replaces the hard-tied full/empty placeholders in the I2C top with real flags.
- Exposes a status byte for the MCU.
- Single clock domain: i2c_core_clk_i.

Parameters:
- DATA_SIZE, 8, width of each stored word.
- DEPTH_LOG2, 4, log2 of FIFO depth; depth = 2**DEPTH_LOG2 = 16 words.
- AF_THRESHOLD, 12, count at or above which almost_full_o asserts. Legal range 1..depth.

Ports:
- i2c_core_clk_i, input, 1: I2C core clock; all state updates on its rising edge.
- reset_i, input, 1: synchronous, active-high reset.
- w_fifo_en_i, input, 1: write request from the MCU side.
- data_i, input, DATA_SIZE: write data, sampled when w_fifo_en_i=1.
- r_fifo_en_i, input, 1: read request from the master FSM.
- clear_flags_i, input, 1: clears the sticky overflow/underflow flags.
- data_o, output, DATA_SIZE: read data; feeds data_transmit_i of the I2C top.
- full_o, output, 1: count == depth.
- empty_o, output, 1: count == 0.
- almost_full_o, output, 1: count >= AF_THRESHOLD.
- overflow_o, output, 1: sticky; a write was attempted while full.
- underflow_o, output, 1: sticky; a read was attempted while empty.
- count_o, output, DEPTH_LOG2+1: number of stored words, 0..depth.
- status_o, output, 8: bit map {2'b00, data_valid, underflow, overflow, almost_full, full, empty} (bit7..bit0).

Behaviour:
- Reset (reset_i=1 at a clock edge):
  - wptr=0, rptr=0, count_o=0.
  - empty_o=1, full_o=0, almost_full_o=0.
  - overflow_o=0, underflow_o=0, data_o=0, data_valid=0, status_o=8'h01.
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored words; any r/w request in the same cycle is ignored.
- Pointers:
  - wptr and rptr are DEPTH_LOG2+1 bits; the low DEPTH_LOG2 bits address memory.
  - The MSB distinguishes full from empty.
  - Wrap-around from depth-1 to 0 is natural binary rollover.
- Derived outputs:
  - count_o = wptr - rptr, modulo 2**(DEPTH_LOG2+1).
  - Flags are combinational from the registered pointers, so they are valid in the cycle after the pointer update.
- Write accept: w_fifo_en_i & ~full_o → mem[wptr]<=data_i, wptr<=wptr+1.
- Write while full:
  - No memory or pointer change; overflow_o<=1.
  - Exception: if r_fifo_en_i=1 in the same cycle, the write is accepted (see simultaneous cases).
- Read accept: r_fifo_en_i & ~empty_o → rptr<=rptr+1.
- Read while empty: ignored; underflow_o<=1.
- Read data timing (default build):
  - data_o<=mem[rptr] on an accepted read; data_valid<=1 for exactly that next cycle.
  - Read latency is 1 clock; data_o holds its value otherwise.
- Simultaneous r/w:
  - Full: both accepted; count unchanged; no overflow.
  - Empty: write accepted, read rejected; underflow set; count becomes 1.
  - Otherwise: both accepted; count unchanged.
- Sticky flags:
  - clear_flags_i=1 clears overflow_o and underflow_o.
  - If a new violation occurs in the same cycle as the clear, set wins.
- almost_full_o uses count_o >= AF_THRESHOLD (unsigned compare, width DEPTH_LOG2+1).

Optional Feature:
- Macro: I2C_TX_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - data_o = mem[rptr] combinationally whenever empty_o=0, and 0 when empty.
  - An accepted read pops the head; the next word appears in the same cycle the pointer advances.
  - data_valid = ~empty_o.
  - Read latency is 0 (data visible before the read strobe).
- Undefined: registered 1-cycle read latency as described in Behaviour.
- Flags, pointers and sticky semantics are identical in both builds.

Test Plan:
1. Reset, then write 8'hA5, 8'h3C on consecutive cycles:
   - count_o=2, empty_o=0.
   - Read once → data_o=8'hA5 one cycle later (FWFT: visible before the read), status bit5=1 for one cycle.
2. Write 16 words 8'h00..8'h0F:
   - full_o=1, count_o=16, almost_full_o=1 from count 12.
   - 17th write 8'hFF → overflow_o=1; memory unchanged.
   - Then drain 16 reads → data sequence 8'h00..8'h0F, empty_o=1.
3. Pointer wrap: perform 40 interleaved write/read pairs → data out equals data in, in order, across two pointer wraps; count_o never exceeds 1.
4. While full, assert w_fifo_en_i (data 8'h77) and r_fifo_en_i together:
   - count_o stays 16, overflow_o stays 0.
   - 8'h77 is read out last after a full drain.
5. Read on empty → underflow_o=1, status_o=8'h11. Then:
   - clear_flags_i=1 alone → 8'h01.
   - clear_flags_i together with another empty read → underflow_o stays 1.
6. Store 5 words, assert reset_i for one cycle with w_fifo_en_i=1 → count_o=0, empty_o=1, status_o=8'h01, data_o=0.
